neureka_multi_source_streamer: RTL and testbench
================================================

// Module: neureka_multi_source_streamer
// PURPOSE
//  N-channel load streamer: NB_CH independent linear/strided read channels share one TCDM read port.
//  Round-robin arbitration, per-channel address generation, in-order response routing via a channel-tag
//  FIFO, and credit-limited per-channel output buffers; a stalled consumer never blocks other channels.
//  Sits between the ctrl FSM and the feat/weight/norm/streamin consumers; replaces static load muxing.
// PARAMETERS
//  NB_CH     4   number of load channels (>=2)
//  DW        288 data width of TCDM word and of each output stream (bits)
//  AW        32  byte address width
//  LW        16  transfer length width (beats)
//  BUF_DEPTH 4   per-channel output buffer depth (beats, >=2, power of 2)
//  MAX_OUTST 8   max outstanding TCDM reads across all channels (power of 2)
// PORTS
//  clk_i          in  1          clock
//  rst_ni         in  1          synchronous active-low reset
//  clear_i        in  1          synchronous soft clear (same effect as reset, plus drain, below)
//  start_i        in  NB_CH      per-channel start pulse; samples base/stride/len of that channel
//  base_i         in  NB_CH*AW   channel start byte address
//  stride_i       in  NB_CH*AW   channel byte stride between beats
//  len_i          in  NB_CH*LW   channel beat count; 0 = no-op
//  busy_o         out NB_CH      channel in RUN or DRAIN
//  done_o         out NB_CH      one-cycle pulse: last beat of channel accepted downstream
//  tcdm_req_o     out 1          read request
//  tcdm_gnt_i     in  1          grant; request accepted when req&gnt
//  tcdm_add_o     out AW         read address
//  tcdm_r_valid_i in  1          response valid; responses return in request order, any latency>=1
//  tcdm_r_data_i  in  DW         response data
//  out_valid_o    out NB_CH      stream valid per channel
//  out_ready_i    in  NB_CH      stream ready per channel
//  out_data_o     out NB_CH*DW   stream data per channel
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge): all outputs 0, FSMs IDLE, buffers/tag FIFO empty, RR pointer 0, drop cnt 0.
//  Channel FSM: IDLE -start_i&len!=0-> RUN (addr=base, issued=0, popped=0); start with len=0 -> done_o pulse
//   next cycle, stays IDLE. RUN -last beat issued(req&gnt)-> DRAIN -last beat popped-> IDLE + done_o.
//   start_i while RUN/DRAIN ignored.
//  Eligibility: RUN, credit>0, tag FIFO not full. credit = BUF_DEPTH - (outstanding_ch + buffered_ch);
//   guarantees buffer never overflows, no response backpressure needed.
//  Arbiter: round-robin from RR pointer; tcdm_req_o=any eligible; add = granted channel's addr.
//   req/add held stable until gnt (no retraction, no channel switch while req&~gnt).
//   On req&gnt: channel addr += stride (mod 2^AW), issued++, tag pushed, RR ptr = winner+1 mod NB_CH.
//  Response: tcdm_r_valid_i pops tag FIFO head, writes data into that channel's buffer same cycle.
//   r_valid with empty tag FIFO and drop cnt 0: ignored (sim assertion fires).
//  Output: out_valid_o[c]=buffer c not empty; pop on valid&ready; data from buffer head, 0 latency.
//   Min latency gnt -> out_valid = TCDM latency + 1 cycle (buffer registered).
//  Simultaneous: push and pop of same buffer in one cycle allowed when full (net 0); tag push&pop same
//   cycle allowed when full; credit computed from registered state (conservative, no comb loop on ready).
//  clear_i: FSMs to IDLE, buffers flushed, no done_o, tag FIFO cleared, drop cnt = outstanding count;
//   next drop cnt responses discarded; no channel eligible until drop cnt = 0.
//  Width rules: counters LW bits; beat count compares issued==len; address wraps silently.
// TESTING
//  1 ch0 base=0x100 stride=36 len=3, ready=1, lat 1 -> adds 0x100,0x124,0x148; 3 beats in order; done_o[0] once.
//  ch0,ch1 start same cycle len=4 each, gnt=1 -> grants alternate 0,1,0,1..; each stream data in issue order.
//  ch1 out_ready=0, len=10 -> ch1 issues exactly BUF_DEPTH=4 reads then stalls; ch0 keeps streaming.
//  gnt held 0 for 5 cycles -> tcdm_req_o and tcdm_add_o constant; tag FIFO unchanged.
//  clear_i with 3 reads outstanding -> next 3 r_valid dropped, no out_valid; new start after drains OK.
//  len=0 start -> no tcdm_req_o, done_o pulse next cycle; rst_ni=0 mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/neureka_multi_source_streamer.sv
// NB_CH strided load channels sharing one TCDM read port: round-robin request arbitration,
// in-order response routing through a channel-tag FIFO, and credit-limited output buffers.
module neureka_multi_source_streamer #(
  parameter int unsigned NB_CH     = 4,
  parameter int unsigned DW        = 288,
  parameter int unsigned AW        = 32,
  parameter int unsigned LW        = 16,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [NB_CH-1:0]    start_i,
  input  logic [NB_CH*AW-1:0] base_i,
  input  logic [NB_CH*AW-1:0] stride_i,
  input  logic [NB_CH*LW-1:0] len_i,
  output logic [NB_CH-1:0]    busy_o,
  output logic [NB_CH-1:0]    done_o,
  output logic                tcdm_req_o,
  input  logic                tcdm_gnt_i,
  output logic [AW-1:0]       tcdm_add_o,
  input  logic                tcdm_r_valid_i,
  input  logic [DW-1:0]       tcdm_r_data_i,
  output logic [NB_CH-1:0]    out_valid_o,
  input  logic [NB_CH-1:0]    out_ready_i,
  output logic [NB_CH*DW-1:0] out_data_o
);

  localparam int CW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int BW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        r_state     [NB_CH];
  state_e        w_state_nxt [NB_CH];
  logic [AW-1:0] r_addr      [NB_CH];
  logic [AW-1:0] r_stride    [NB_CH];
  logic [LW-1:0] r_len       [NB_CH];
  logic [LW-1:0] r_issued    [NB_CH];
  logic [LW-1:0] r_popped    [NB_CH];
  logic [BW:0]   r_outst     [NB_CH];
  logic [BW:0]   r_cnt       [NB_CH];
  logic [BW-1:0] r_wr        [NB_CH];
  logic [BW-1:0] r_rd        [NB_CH];
  logic [DW-1:0] r_buf       [NB_CH][BUF_DEPTH];
  logic [NB_CH-1:0] r_done;

  logic [CW-1:0] r_rr;
  logic [CW-1:0] r_hold_ch;
  logic          r_hold;

  logic [CW-1:0] r_tag [MAX_OUTST];
  logic [TW-1:0] r_tag_wr;
  logic [TW-1:0] r_tag_rd;
  logic [TW:0]   r_tag_cnt;
  logic [TW:0]   r_drop;

  logic [NB_CH-1:0] w_elig;
  logic [NB_CH-1:0] w_gnt_ch;
  logic [NB_CH-1:0] w_push;
  logic [NB_CH-1:0] w_pop;
  logic [NB_CH-1:0] w_last_issue;
  logic [NB_CH-1:0] w_last_pop;
  logic             w_found;
  logic             w_req;
  logic             w_gnt;
  logic [CW-1:0]    w_win;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_resp;
  logic [CW-1:0]    w_resp_ch;
  logic             w_drop_hit;
  logic [TW+1:0]    w_total;

  assign w_tag_full  = (r_tag_cnt == (TW+1)'(MAX_OUTST));
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_drop_hit  = tcdm_r_valid_i && (r_drop != '0);
  assign w_resp      = tcdm_r_valid_i && (r_drop == '0) && !w_tag_empty;
  assign w_resp_ch   = r_tag[r_tag_rd];
  assign w_total     = (TW+2)'(r_drop) + (TW+2)'(r_tag_cnt);

  // Credits count both in-flight reads and buffered beats, so a response always finds room.
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NB_CH; c++) begin
      w_elig[c] = (r_state[c] == S_RUN) && !w_tag_full && (r_drop == '0) &&
                  (((BW+2)'(r_outst[c]) + (BW+2)'(r_cnt[c])) < (BW+2)'(BUF_DEPTH));
    end
  end

  // A request left ungranted is replayed unchanged from the hold register.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int c = 0; c < NB_CH; c++) begin
      if (!w_found && w_elig[c] && (CW'(c) >= r_rr)) begin
        w_win   = CW'(c);
        w_found = 1'b1;
      end
    end
    for (int c = 0; c < NB_CH; c++) begin
      if (!w_found && w_elig[c]) begin
        w_win   = CW'(c);
        w_found = 1'b1;
      end
    end
    if (r_hold) begin
      w_win = r_hold_ch;
    end
    w_req = r_hold || w_found;
  end

  assign w_gnt      = w_req && tcdm_gnt_i;
  assign tcdm_req_o = w_req;
  assign tcdm_add_o = w_req ? r_addr[w_win] : '0;
  assign done_o     = r_done;

  always_comb begin
    w_gnt_ch     = '0;
    w_push       = '0;
    w_pop        = '0;
    w_last_issue = '0;
    w_last_pop   = '0;
    busy_o       = '0;
    out_valid_o  = '0;
    out_data_o   = '0;
    for (int c = 0; c < NB_CH; c++) begin
      w_gnt_ch[c]     = w_gnt && (w_win == CW'(c));
      w_push[c]       = w_resp && (w_resp_ch == CW'(c));
      out_valid_o[c]  = (r_cnt[c] != '0);
      w_pop[c]        = out_valid_o[c] && out_ready_i[c];
      w_last_issue[c] = w_gnt_ch[c] && (r_issued[c] == r_len[c] - LW'(1));
      w_last_pop[c]   = w_pop[c] && (r_popped[c] == r_len[c] - LW'(1));
      busy_o[c]       = (r_state[c] != S_IDLE);
      if (out_valid_o[c]) begin
        out_data_o[c*DW +: DW] = r_buf[c][r_rd[c]];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      case (r_state[c])
        S_IDLE:  if (start_i[c] && (len_i[c*LW +: LW] != '0)) w_state_nxt[c] = S_RUN;
        S_RUN:   if (w_last_issue[c]) w_state_nxt[c] = S_DRAIN;
        S_DRAIN: if (w_last_pop[c]) w_state_nxt[c] = S_IDLE;
        default: w_state_nxt[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (!rst_ni || clear_i) begin
        r_state[c] <= S_IDLE;
      end else begin
        r_state[c] <= w_state_nxt[c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (!rst_ni || clear_i) begin
        r_addr[c]   <= '0;
        r_stride[c] <= '0;
        r_len[c]    <= '0;
        r_issued[c] <= '0;
        r_popped[c] <= '0;
        r_outst[c]  <= '0;
        r_cnt[c]    <= '0;
        r_wr[c]     <= '0;
        r_rd[c]     <= '0;
        r_done[c]   <= 1'b0;
      end else begin
        r_done[c] <= ((r_state[c] == S_IDLE) && start_i[c] && (len_i[c*LW +: LW] == '0)) ||
                     ((r_state[c] == S_DRAIN) && w_last_pop[c]);
        if ((r_state[c] == S_IDLE) && start_i[c]) begin
          r_addr[c]   <= base_i[c*AW +: AW];
          r_stride[c] <= stride_i[c*AW +: AW];
          r_len[c]    <= len_i[c*LW +: LW];
          r_issued[c] <= '0;
          r_popped[c] <= '0;
        end else begin
          if (w_gnt_ch[c]) begin
            r_addr[c]   <= r_addr[c] + r_stride[c];
            r_issued[c] <= r_issued[c] + LW'(1);
          end
          if (w_pop[c]) begin
            r_popped[c] <= r_popped[c] + LW'(1);
          end
        end
        r_outst[c] <= r_outst[c] + (BW+1)'(w_gnt_ch[c]) - (BW+1)'(w_push[c]);
        r_cnt[c]   <= r_cnt[c] + (BW+1)'(w_push[c]) - (BW+1)'(w_pop[c]);
        r_wr[c]    <= r_wr[c] + BW'(w_push[c]);
        r_rd[c]    <= r_rd[c] + BW'(w_pop[c]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (w_push[c]) begin
        r_buf[c][r_wr[c]] <= tcdm_r_data_i;
      end
    end
    if (w_gnt) begin
      r_tag[r_tag_wr] <= w_win;
    end
  end

  // On clear every read still in flight becomes a response to discard.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_drop    <= '0;
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_tag_cnt <= '0;
      r_hold    <= 1'b0;
      r_hold_ch <= '0;
      r_rr      <= '0;
    end else if (clear_i) begin
      r_drop    <= (TW+1)'(w_total + (TW+2)'(w_gnt) -
                   (TW+2)'(tcdm_r_valid_i && (w_total != '0)));
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_tag_cnt <= '0;
      r_hold    <= 1'b0;
      r_hold_ch <= '0;
      r_rr      <= '0;
    end else begin
      if (w_drop_hit) begin
        r_drop <= r_drop - (TW+1)'(1);
      end
      r_tag_wr  <= r_tag_wr + TW'(w_gnt);
      r_tag_rd  <= r_tag_rd + TW'(w_resp);
      r_tag_cnt <= r_tag_cnt + (TW+1)'(w_gnt) - (TW+1)'(w_resp);
      r_hold    <= w_req && !tcdm_gnt_i;
      r_hold_ch <= w_win;
      if (w_gnt) begin
        r_rr <= (w_win == CW'(NB_CH - 1)) ? '0 : w_win + CW'(1);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(tcdm_r_valid_i && w_tag_empty && (r_drop == '0)));

endmodule

// File: tb/tb_neureka_multi_source_streamer.sv
// Directed bench for neureka_multi_source_streamer: in-order TCDM responder model with
// configurable latency, per-channel expected-beat queues, and table-driven single-channel runs.
module tb_neureka_multi_source_streamer;

  localparam int NB_CH = 4;
  localparam int DW    = 288;
  localparam int AW    = 32;
  localparam int LW    = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear;
  logic [NB_CH-1:0]    start;
  logic [NB_CH*AW-1:0] base;
  logic [NB_CH*AW-1:0] stride;
  logic [NB_CH*LW-1:0] len;
  logic [NB_CH-1:0]    busy;
  logic [NB_CH-1:0]    done;
  logic                tcdmReq;
  logic                tcdmGnt;
  logic [AW-1:0]       tcdmAdd;
  logic                tcdmRValid;
  logic [DW-1:0]       tcdmRData;
  logic [NB_CH-1:0]    outValid;
  logic [NB_CH-1:0]    outReady;
  logic [NB_CH*DW-1:0] outData;

  always #5 clk = ~clk;

  neureka_multi_source_streamer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .base_i        (base),
    .stride_i      (stride),
    .len_i         (len),
    .busy_o        (busy),
    .done_o        (done),
    .tcdm_req_o    (tcdmReq),
    .tcdm_gnt_i    (tcdmGnt),
    .tcdm_add_o    (tcdmAdd),
    .tcdm_r_valid_i(tcdmRValid),
    .tcdm_r_data_i (tcdmRData),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .out_data_o    (outData)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  typedef struct {
    int            ch;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    int            len;
    int            lat;
    logic [AW-1:0] add0;
    logic [AW-1:0] add1;
    logic [AW-1:0] addL;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            lat = 1;
  int            gntBudget = -1;
  bit            gntEn = 1'b1;
  pend_t         pend[$];
  logic [AW-1:0] gntLog[$];
  logic [AW-1:0] expQ[NB_CH][$];
  int            doneCnt[NB_CH];
  int            beatCnt[NB_CH];

  function automatic logic [DW-1:0] dataOf(input logic [AW-1:0] a);
    return {9{a ^ 32'h5A00_00C3}};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // TCDM model: grants under gntEn/gntBudget, answers in request order after lat cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      tcdmRValid = 1'b0;
      tcdmRData  = '0;
      tcdmGnt    = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        tcdmRValid = 1'b1;
        tcdmRData  = dataOf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        tcdmRValid = 1'b0;
        tcdmRData  = '0;
      end
      tcdmGnt = gntEn && (gntBudget != 0);
      if (tcdmReq && tcdmGnt) begin
        pend.push_back('{tcdmAdd, cyc + lat});
        gntLog.push_back(tcdmAdd);
        if (gntBudget > 0) gntBudget--;
      end
    end
  end

  // Stream monitor: every accepted beat must match the head of that channel's expected queue.
  always @(negedge clk) begin
    #1;
    if (rst_n && !clear) begin
      for (int c = 0; c < NB_CH; c++) begin
        if (done[c]) doneCnt[c]++;
        if (outValid[c] && outReady[c]) begin
          if (expQ[c].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ch%0d unexpected beat actual=%0h required=none", c, outData[c*DW +: DW]);
          end else begin
            checkOutput($sformatf("ch%0d beat%0d data", c, beatCnt[c]), outData[c*DW +: DW],
                        dataOf(expQ[c].pop_front()));
          end
          beatCnt[c]++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input int ch, input logic [AW-1:0] b, input logic [AW-1:0] s, input int l);
    logic [AW-1:0] a;
    start[ch]             = 1'b1;
    base[ch*AW +: AW]     = b;
    stride[ch*AW +: AW]   = s;
    len[ch*LW +: LW]      = LW'(l);
    a = b;
    for (int k = 0; k < l; k++) begin
      expQ[ch].push_back(a);
      a = a + s;
    end
  endtask

  task automatic applyStimulus();
    step(1);
    start = '0;
  endtask

  task automatic waitDone(input int ch, input int target, input string name);
    int n = 0;
    while (doneCnt[ch] < target && n < 500) begin
      step(1);
      n++;
    end
    checkOutput(name, DW'(doneCnt[ch]), DW'(target));
  endtask

  vec_t          vecs[4];
  logic [AW-1:0] altExp[8];
  int            d0;
  int            b0;
  int            n1;

  initial begin
    vecs[0] = '{0, 32'h0000_0100, 32'd36, 3, 1, 32'h0000_0100, 32'h0000_0124, 32'h0000_0148};
    vecs[1] = '{2, 32'h0000_2000, 32'd4,  5, 3, 32'h0000_2000, 32'h0000_2004, 32'h0000_2010};
    vecs[2] = '{3, 32'hFFFF_FFF0, 32'h10, 3, 2, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010};
    vecs[3] = '{1, 32'h0000_0400, 32'd0,  2, 1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0400};
    altExp  = '{32'h1000, 32'h5000, 32'h1004, 32'h5004, 32'h1008, 32'h5008, 32'h100C, 32'h500C};

    rst_n = 1'b0; clear = 1'b0; start = '0; base = '0; stride = '0; len = '0; outReady = '1;
    for (int c = 0; c < NB_CH; c++) begin doneCnt[c] = 0; beatCnt[c] = 0; end
    step(3);
    checkOutput("reset busy", DW'(busy), '0);
    checkOutput("reset done", DW'(done), '0);
    checkOutput("reset out_valid", DW'(outValid), '0);
    checkOutput("reset req", DW'(tcdmReq), '0);
    checkOutput("reset add", DW'(tcdmAdd), '0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      gntLog.delete();
      d0 = doneCnt[vecs[i].ch];
      b0 = beatCnt[vecs[i].ch];
      arm(vecs[i].ch, vecs[i].base, vecs[i].stride, vecs[i].len);
      applyStimulus();
      waitDone(vecs[i].ch, d0 + 1, $sformatf("vec%0d done reached", i));
      step(3);
      checkOutput($sformatf("vec%0d done once", i), DW'(doneCnt[vecs[i].ch]), DW'(d0 + 1));
      checkOutput($sformatf("vec%0d grant count", i), DW'(gntLog.size()), DW'(vecs[i].len));
      checkOutput($sformatf("vec%0d beat count", i), DW'(beatCnt[vecs[i].ch] - b0), DW'(vecs[i].len));
      if (gntLog.size() >= vecs[i].len) begin
        checkOutput($sformatf("vec%0d add first", i), DW'(gntLog[0]), DW'(vecs[i].add0));
        checkOutput($sformatf("vec%0d add second", i), DW'(gntLog[1]), DW'(vecs[i].add1));
        checkOutput($sformatf("vec%0d add last", i), DW'(gntLog[vecs[i].len - 1]), DW'(vecs[i].addL));
      end
    end

    // Zero-length start: no request, done pulse on the following cycle only.
    gntLog.delete();
    arm(2, 32'h50, 32'd4, 0);
    applyStimulus();
    checkOutput("len0 done pulse", DW'(done), DW'(4'b0100));
    checkOutput("len0 no req", DW'(tcdmReq), '0);
    step(1);
    checkOutput("len0 done cleared", DW'(done), '0);
    checkOutput("len0 no grants", DW'(gntLog.size()), '0);

    // Reset in the middle of a run.
    lat = 3;
    arm(0, 32'h600, 32'd4, 8);
    applyStimulus();
    step(3);
    checkOutput("midrun busy before reset", DW'(busy[0]), DW'(1));
    rst_n = 1'b0;
    step(1);
    checkOutput("midrun reset busy", DW'(busy), '0);
    checkOutput("midrun reset req/add", DW'({tcdmReq, tcdmAdd}), '0);
    checkOutput("midrun reset valid/done", DW'({outValid, done}), '0);
    checkOutput("midrun reset data", DW'(|outData), '0);
    expQ[0].delete();
    rst_n = 1'b1;
    step(2);

    // Two channels started together alternate grants.
    lat = 1;
    gntLog.delete();
    d0 = doneCnt[0];
    n1 = doneCnt[1];
    arm(0, 32'h1000, 32'd4, 4);
    arm(1, 32'h5000, 32'd4, 4);
    applyStimulus();
    waitDone(0, d0 + 1, "alt ch0 done");
    waitDone(1, n1 + 1, "alt ch1 done");
    checkOutput("alt grant count", DW'(gntLog.size()), DW'(8));
    if (gntLog.size() == 8) begin
      for (int k = 0; k < 8; k++) checkOutput($sformatf("alt grant%0d", k), DW'(gntLog[k]), DW'(altExp[k]));
    end

    // Stalled consumer on ch1 limits it to BUF_DEPTH reads while ch0 completes.
    gntLog.delete();
    outReady[1] = 1'b0;
    d0 = doneCnt[0];
    n1 = doneCnt[1];
    b0 = beatCnt[1];
    arm(1, 32'h3000, 32'd4, 10);
    arm(0, 32'h0100, 32'd4, 6);
    applyStimulus();
    step(40);
    begin
      int cnt = 0;
      foreach (gntLog[k]) if (gntLog[k] >= 32'h3000 && gntLog[k] < 32'h4000) cnt++;
      checkOutput("stall ch1 reads", DW'(cnt), DW'(4));
    end
    checkOutput("stall ch0 done", DW'(doneCnt[0]), DW'(d0 + 1));
    checkOutput("stall ch1 busy/valid", DW'({busy[1], outValid[1]}), DW'(2'b11));
    outReady[1] = 1'b1;
    waitDone(1, n1 + 1, "stall ch1 done");
    checkOutput("stall ch1 beats", DW'(beatCnt[1] - b0), DW'(10));

    // Grant withheld: request and address stay on ch1 even once ch3 is eligible.
    gntEn = 1'b0;
    step(2);
    gntLog.delete();
    d0 = doneCnt[1];
    n1 = doneCnt[3];
    arm(1, 32'h8000, 32'd8, 2);
    applyStimulus();
    arm(3, 32'h7000, 32'd8, 2);
    applyStimulus();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold cycle%0d req/add", k), DW'({tcdmReq, tcdmAdd}), DW'({1'b1, 32'h8000}));
      step(1);
    end
    gntEn = 1'b1;
    waitDone(1, d0 + 1, "hold ch1 done");
    waitDone(3, n1 + 1, "hold ch3 done");
    checkOutput("hold grant count", DW'(gntLog.size()), DW'(4));
    if (gntLog.size() >= 2) begin
      checkOutput("hold first grant", DW'(gntLog[0]), DW'(32'h8000));
      checkOutput("hold second grant", DW'(gntLog[1]), DW'(32'h7000));
    end

    // Clear with three reads in flight: their responses must be discarded.
    lat = 10;
    gntBudget = 3;
    gntLog.delete();
    d0 = doneCnt[0];
    b0 = beatCnt[0];
    arm(0, 32'h900, 32'd4, 8);
    applyStimulus();
    step(6);
    checkOutput("clear grants before", DW'(gntLog.size()), DW'(3));
    clear = 1'b1;
    expQ[0].delete();
    step(1);
    clear = 1'b0;
    checkOutput("clear busy/valid", DW'({busy, outValid}), '0);
    step(15);
    checkOutput("clear drained valid", DW'(outValid), '0);
    checkOutput("clear no beats", DW'(beatCnt[0] - b0), '0);
    checkOutput("clear no done", DW'(doneCnt[0]), DW'(d0));
    checkOutput("clear no req", DW'(tcdmReq), '0);
    gntBudget = -1;
    lat = 1;
    arm(0, 32'hA00, 32'd4, 2);
    applyStimulus();
    waitDone(0, d0 + 1, "post-clear done");
    step(2);
    checkOutput("post-clear beats", DW'(beatCnt[0] - b0), DW'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
